// File: rtl/fb_pixel_writer.sv
// Framebuffer pixel writer: two-stage clip/address pipeline plus a sequential
// background clear that drains in-flight pixels before it starts.
module fb_pixel_writer #(
  parameter int CORDW     = 16,
  parameter int CIDXW     = 4,
  parameter int FB_WIDTH  = 320,
  parameter int FB_HEIGHT = 180,
  parameter int FB_ADDRW  = 16,
  parameter int BG_CIDX   = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    drawing,
  input  logic signed [CORDW-1:0] x,
  input  logic signed [CORDW-1:0] y,
  input  logic [CIDXW-1:0]        cidx,
  output logic                    oe,
  output logic                    fb_we,
  output logic [FB_ADDRW-1:0]     fb_addr,
  output logic [CIDXW-1:0]        fb_din,
  output logic                    busy,
  output logic                    clear_done,
  output logic [15:0]             clip_cnt
);

  localparam logic [FB_ADDRW-1:0]     LAST_ADDR = FB_ADDRW'(FB_WIDTH * FB_HEIGHT - 1);
  localparam logic [FB_ADDRW-1:0]     ONE_ADDR  = FB_ADDRW'(1);
  localparam logic [FB_ADDRW-1:0]     WIDTH_A   = FB_ADDRW'(FB_WIDTH);
  localparam logic signed [CORDW-1:0] WIDTH_S   = CORDW'(FB_WIDTH);
  localparam logic signed [CORDW-1:0] HEIGHT_S  = CORDW'(FB_HEIGHT);
  localparam logic [CIDXW-1:0]        BG        = CIDXW'(BG_CIDX);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    CLEAR = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state, next_state;

  logic                    accept;
  logic                    in_bounds;
  logic                    s1_valid;
  logic                    s1_inb;
  logic [CIDXW-1:0]        s1_cidx;
  logic signed [CORDW-1:0] s1_x;
  logic signed [CORDW-1:0] s1_y;
  logic [FB_ADDRW-1:0]     clr_addr;

  assign oe        = (state == IDLE);
  assign accept    = drawing && oe;
  // Sign bit low means the coordinate is non-negative.
  assign in_bounds = !x[CORDW-1] && (x < WIDTH_S) && !y[CORDW-1] && (y < HEIGHT_S);

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (clear) next_state = DRAIN; else next_state = IDLE;
      DRAIN:   if (!s1_valid) next_state = CLEAR; else next_state = DRAIN;
      CLEAR:   if (clr_addr == LAST_ADDR) next_state = DONE; else next_state = CLEAR;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_inb   <= 1'b0;
      s1_cidx  <= '0;
      s1_x     <= '0;
      s1_y     <= '0;
      clip_cnt <= 16'd0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_inb  <= in_bounds;
        s1_cidx <= cidx;
        s1_x    <= x;
        s1_y    <= y;
        if (!in_bounds && (clip_cnt != 16'hFFFF)) clip_cnt <= clip_cnt + 16'd1;
      end
    end
  end

  // Clear and pixel writes never collide: CLEAR is only entered once stage 1 is empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fb_we    <= 1'b0;
      fb_addr  <= '0;
      fb_din   <= '0;
      clr_addr <= '0;
    end else if (next_state == CLEAR) begin
      fb_we  <= 1'b1;
      fb_din <= BG;
      if (state == CLEAR) begin
        clr_addr <= clr_addr + ONE_ADDR;
        fb_addr  <= clr_addr + ONE_ADDR;
      end else begin
        clr_addr <= '0;
        fb_addr  <= '0;
      end
    end else if (s1_valid && s1_inb) begin
      fb_we   <= 1'b1;
      fb_addr <= FB_ADDRW'(s1_y) * WIDTH_A + FB_ADDRW'(s1_x);
      fb_din  <= s1_cidx;
    end else begin
      fb_we <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy       <= 1'b0;
      clear_done <= 1'b0;
    end else begin
      busy       <= (next_state == DRAIN) || (next_state == CLEAR);
      clear_done <= (next_state == DONE);
    end
  end

endmodule

// File: tb/tb_fb_pixel_writer.sv
// Scoreboard bench for fb_pixel_writer; a second instance exercises clip-counter
// saturation concurrently with the long clear on the main instance.
module tb_fb_pixel_writer;

  localparam int BG = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst, clear, drawing;
  logic signed [15:0] x, y;
  logic [3:0]         cidx;
  logic               oe, fb_we, busy, clear_done;
  logic [15:0]        fb_addr, clip_cnt;
  logic [3:0]         fb_din;

  logic               c_rst, c_clear, c_drawing;
  logic signed [15:0] c_x, c_y;
  logic [3:0]         c_cidx;
  logic               c_oe, c_fb_we, c_busy, c_clear_done;
  logic [15:0]        c_fb_addr, c_clip_cnt;
  logic [3:0]         c_fb_din;

  fb_pixel_writer #(.BG_CIDX(BG)) dut (
    .clk(clk), .rst(rst), .clear(clear), .drawing(drawing), .x(x), .y(y), .cidx(cidx),
    .oe(oe), .fb_we(fb_we), .fb_addr(fb_addr), .fb_din(fb_din), .busy(busy),
    .clear_done(clear_done), .clip_cnt(clip_cnt)
  );

  fb_pixel_writer dut_clip (
    .clk(clk), .rst(c_rst), .clear(c_clear), .drawing(c_drawing), .x(c_x), .y(c_y),
    .cidx(c_cidx), .oe(c_oe), .fb_we(c_fb_we), .fb_addr(c_fb_addr), .fb_din(c_fb_din),
    .busy(c_busy), .clear_done(c_clear_done), .clip_cnt(c_clip_cnt)
  );

  typedef struct {
    int addr;
    int din;
    int cyc;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  // Monitor: every framebuffer write must match the oldest expected write, in its cycle.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc < cyc) begin
      e = q.pop_front();
      checks++;
      failures++;
      $display("FAIL missing_write: got no write required addr=%0d din=%0d at cyc=%0d",
               e.addr, e.din, e.cyc);
    end
    if (fb_we === 1'b1) begin
      checks++;
      if (q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write: got addr=%0d din=%0d cyc=%0d required no write",
                 fb_addr, fb_din, cyc);
      end else begin
        e = q.pop_front();
        if (fb_addr !== e.addr[15:0] || fb_din !== e.din[3:0] || cyc != e.cyc) begin
          failures++;
          $display("FAIL write: got addr=%0d din=%0d cyc=%0d required addr=%0d din=%0d cyc=%0d",
                   fb_addr, fb_din, cyc, e.addr, e.din, e.cyc);
        end
      end
    end
    if (c_fb_we === 1'b1) begin
      checks++;
      failures++;
      $display("FAIL clip_dut_write: got write addr=%0d required no write", c_fb_addr);
    end
  end

  task automatic pix(input int px, input int py, input int pc, input bit wr, input int addr);
    @(negedge clk);
    drawing = 1'b1;
    x       = px[15:0];
    y       = py[15:0];
    cidx    = pc[3:0];
    if (wr) q.push_back('{addr, pc, cyc + 2});
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      drawing = 1'b0;
      clear   = 1'b0;
    end
  endtask

  task automatic main_seq();
    int n;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_oe", oe, 1);
    chk("rst_fb_we", fb_we, 0);
    chk("rst_fb_addr", fb_addr, 0);
    chk("rst_fb_din", fb_din, 0);
    chk("rst_busy", busy, 0);
    chk("rst_clear_done", clear_done, 0);
    chk("rst_clip_cnt", clip_cnt, 0);
    @(negedge clk);
    rst = 1'b0;

    pix(0, 0, 3, 1'b1, 0);
    idle(4);
    chk("origin_drained", q.size(), 0);

    pix(319, 179, 1, 1'b1, 57599);
    pix(5, 2, 7, 1'b1, 645);
    pix(6, 2, 9, 1'b1, 646);
    idle(4);
    chk("corner_b2b_drained", q.size(), 0);

    pix(320, 5, 6, 1'b0, 0);
    pix(-1, 5, 6, 1'b0, 0);
    pix(5, 180, 6, 1'b0, 0);
    idle(3);
    chk("clip_cnt_3", clip_cnt, 3);

    // Clear with an idle pipeline; clear re-pulse and drawing while oe is low are ignored.
    @(negedge clk);
    clear = 1'b1;
    n = cyc;
    for (int i = 0; i < 57600; i++) q.push_back('{i, BG, n + 2 + i});
    @(negedge clk);
    clear   = 1'b1;
    drawing = 1'b1;
    x = 16'sd1; y = 16'sd1; cidx = 4'd4;
    #1;
    chk("clear_oe_low", oe, 0);
    chk("clear_busy", busy, 1);
    idle(2);
    while (cyc < n + 57602) @(negedge clk);
    #1;
    chk("done_clear_done", clear_done, 1);
    chk("done_busy", busy, 0);
    chk("done_oe", oe, 0);
    @(negedge clk);
    #1;
    chk("after_done_clear_done", clear_done, 0);
    chk("after_done_oe", oe, 1);
    chk("clear_drained", q.size(), 0);

    // Pixel accepted alongside clear lands first; reset after 100 clear writes.
    @(negedge clk);
    clear = 1'b1; drawing = 1'b1;
    x = 16'sd10; y = 16'sd1; cidx = 4'd2;
    n = cyc;
    q.push_back('{330, 2, n + 2});
    for (int i = 0; i < 100; i++) q.push_back('{i, BG, n + 3 + i});
    idle(1);
    while (cyc < n + 102) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_mid_fb_we", fb_we, 0);
    chk("rst_mid_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_release_oe", oe, 1);
    idle(200);
    chk("rst_release_busy", busy, 0);
    chk("rst_clip_cleared", clip_cnt, 0);
    chk("abort_drained", q.size(), 0);
  endtask

  task automatic clip_seq();
    repeat (3) @(negedge clk);
    c_rst = 1'b0;
    for (int i = 0; i < 65540; i++) begin
      @(negedge clk);
      c_drawing = 1'b1;
      case (i % 3)
        0:       begin c_x = 16'sd320; c_y = 16'sd5;   end
        1:       begin c_x = -16'sd1;  c_y = 16'sd5;   end
        default: begin c_x = 16'sd5;   c_y = 16'sd180; end
      endcase
      if (i == 65533) begin
        @(negedge clk);
        c_drawing = 1'b0;
        #1;
        chk("clip_cnt_65534", c_clip_cnt, 65534);
      end
    end
    @(negedge clk);
    c_drawing = 1'b0;
    #1;
    chk("clip_cnt_saturated", c_clip_cnt, 65535);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion required finish before timeout");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; clear = 1'b0; drawing = 1'b0;
    x = 16'sd0; y = 16'sd0; cidx = 4'd0;
    c_rst = 1'b1; c_clear = 1'b0; c_drawing = 1'b0;
    c_x = 16'sd0; c_y = 16'sd0; c_cidx = 4'd0;
    fork
      main_seq();
      clip_seq();
    join
    idle(3);
    chk("scoreboard_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
